apu_pads_bus_seq: RTL and testbench
===================================

// Module: apu_pads_bus_seq
// PURPOSE
//  Second-generation APU pad block: registered external-bus sequencer between the 6502 core/DMA and the chip pads.
//  Generates free-running M2 and sequences address, R/W and data pads per bus period.
//  Captures read data and filters/synchronises N external IRQ pads into /IRQ for the core.
//  Pads are split into separate in/out/oe ports; tristate cells live in the pad ring.
// PARAMETERS
//  AW        16  address pad width
//  DW        8   data pad width
//  NIRQ      1   number of external active-low IRQ pads
//  M2_LO     5   CLK cycles M2 is low per bus period (>=2)
//  M2_HI     7   CLK cycles M2 is high per bus period (>=2)
//  IRQ_FILT  2   consecutive synced-low cycles needed to accept an IRQ pad (>=1)
// PORTS
//  CLK        in   1     master clock, all state on rising edge
//  n_RES      in   1     asynchronous active-low reset
//  DBG        in   1     test mode; releases M2 pad during reset
//  req        in   1     core/DMA requests a bus cycle this period
//  rw         in   1     1=read, 0=write
//  addr       in   AW    cycle address
//  wdata      in   DW    write data
//  ack        out  1     one-CLK pulse: cycle complete
//  rdata      out  DW    read data, valid with ack
//  A_out/A_oe out  AW/1  address pad value / enable
//  RW_out/RW_oe out 1/1  R/W pad value / enable
//  D_in       in   DW    data pad input
//  D_out/D_oe out  DW/1  data pad value / enable
//  M2_out/M2_oe out 1/1  M2 pad value / enable
//  n_IRQ_pad  in   NIRQ  external IRQ pads, active-low
//  Timer_Int  in   1     internal timer/DMC interrupt, active-high
//  n_IRQ_core out  1     /IRQ to core, registered
// BEHAVIOUR
//  Reset: n_RES asserts asynchronously. Deassertion is resynchronised by a 2-flop sync; the internal reset releases on the 2nd CLK edge after n_RES rises.
//  Reset values: ack=0, rdata=0, A_oe=RW_oe=D_oe=0, A_out=0, RW_out=1, D_out=0, M2_out=0, M2_oe=~DBG (combinational), n_IRQ_core=1; sync/filter flops cleared.
//  Out of reset: M2_oe=1, A_oe=RW_oe=1.
//  Period FSM, states PH1 -> PH2 -> PH1 (no idle state). Phase counter is modulo M2_LO+M2_HI. The first cycle after reset release is PH1 count 0.
//   PH1: M2_out=0 for M2_LO cycles. On PH1 count 0, latch req/rw/addr/wdata.
//        req=1: drive A_out=addr, RW_out=rw.
//        req=0: dummy read; A_out holds its previous value, RW_out=1, no ack.
//   PH2: M2_out=1 for M2_HI cycles.
//        Write: D_oe=1 and D_out=latched wdata from the first PH2 cycle through one cycle after M2 falls (hold); D_oe=0 otherwise.
//        Read: D_in is sampled on the last PH2 cycle into rdata.
//  ack: pulses on PH1 count 0 following a requested period; rdata is valid in the same cycle.
//   Back-to-back: if req=1 in that cycle, the next cycle is latched at once (zero gap).
//  req/addr change mid-period are ignored until the next PH1 count 0.
//  Reset mid-period: the cycle is aborted, no ack, all pads release immediately.
//  IRQ: each n_IRQ_pad bit -> 2-flop sync -> saturating counter of consecutive synced-low cycles.
//   A bit is accepted when its count = IRQ_FILT; it clears in the first cycle its synced value is high.
//   n_IRQ_core <= ~(|accepted | Timer_Int).
//   Latency from pad low: 3+IRQ_FILT edges. Timer_Int: 1 edge. Deassertion: 3 edges (pad), 1 edge (timer).
// CONFIGURATION
//  APU_PADS_OPENBUS_EN defined:
//   - Adds input D_driven (1 bit) and an open-bus latch that updates with every driven write value and every sampled read value.
//   - Read with D_driven=0 on the sampling cycle: rdata = latch value, and the latch is unchanged.
//  Undefined: no D_driven port, no latch; rdata = D_in always.
// TESTING
//  Reset, DBG=0: M2_oe=1, M2_out=0, other oe=0, n_IRQ_core=1. Same with DBG=1 -> M2_oe=0. Release -> PH1 count 0 on 2nd edge.
//  Read, M2_LO=5 M2_HI=7, req=1 rw=1 addr=16'h4015, D_in=8'hA5:
//   - M2 low 5 / high 7; A_out=4015, RW_out=1, D_oe=0.
//   - ack=1 with rdata=A5 12 cycles after latch.
//  Write addr=16'h2006 wdata=8'h3C, then back-to-back read:
//   - D_oe=1, D_out=3C for 8 cycles (7 high + 1 hold).
//   - ack, then the read is latched in the same cycle.
//  IRQ_FILT=2:
//   - 1-cycle low glitch on n_IRQ_pad -> n_IRQ_core stays 1.
//   - Held low -> n_IRQ_core=0 at edge 5.
//   - Timer_Int=1 -> n_IRQ_core=0 after 1 edge.
//  n_RES low during PH2 of a write: D_oe, A_oe, RW_oe drop at once, no ack; after release the FSM restarts at PH1.
//  OPENBUS_EN: write 8'h5A, then read with D_driven=0 -> rdata=5A; read with D_driven=1, D_in=11 -> rdata=11.

Source files
------------

// File: rtl/apu_pads_bus_seq.sv
// apu_pads_bus_seq
//  Registered external-bus sequencer between the 6502 core/DMA and the chip
//  pads. Generates a free-running M2, sequences address / R/W / data pads once
//  per bus period, captures read data, and filters/synchronises the external
//  IRQ pads into a registered /IRQ for the core.
//
//  Optional feature macro: APU_PADS_OPENBUS_EN
//   defined   - adds input D_driven and an open-bus latch; an undriven read
//               returns the last value seen on the data bus.
//   undefined - no D_driven port, rdata is always the sampled D_in.
//
//  Ports
//   CLK                 master clock, all state on rising edge
//   n_RES               asynchronous active-low reset (release resynchronised)
//   DBG                 test mode, releases the M2 pad while in reset
//   req/rw/addr/wdata   bus request, sampled at the start of each period
//   ack/rdata           one-cycle completion pulse, read data valid with ack
//   A_out/A_oe          address pad value / enable
//   RW_out/RW_oe        R/W pad value / enable (1 = read)
//   D_in/D_out/D_oe     data pad input / value / enable
//   M2_out/M2_oe        M2 pad value / enable
//   n_IRQ_pad           external IRQ pads, active-low
//   Timer_Int           internal timer/DMC interrupt, active-high
//   n_IRQ_core          /IRQ to the core, registered
//   D_driven            (open-bus build only) data bus is being driven
module apu_pads_bus_seq #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int NIRQ     = 1,
  parameter int M2_LO    = 5,
  parameter int M2_HI    = 7,
  parameter int IRQ_FILT = 2
) (
  input  logic            CLK,
  input  logic            n_RES,
  input  logic            DBG,
  input  logic            req,
  input  logic            rw,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            ack,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   A_out,
  output logic            A_oe,
  output logic            RW_out,
  output logic            RW_oe,
  input  logic [DW-1:0]   D_in,
`ifdef APU_PADS_OPENBUS_EN
  input  logic            D_driven,
`endif
  output logic [DW-1:0]   D_out,
  output logic            D_oe,
  output logic            M2_out,
  output logic            M2_oe,
  input  logic [NIRQ-1:0] n_IRQ_pad,
  input  logic            Timer_Int,
  output logic            n_IRQ_core
);

  localparam int PER = M2_LO + M2_HI;
  localparam int CW  = $clog2(PER);
  localparam int FW  = $clog2(IRQ_FILT + 1);

  // Reset release resynchroniser; assertion is immediate, release takes two edges.
  logic [1:0] rst_sync_reg;
  logic       run;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) rst_sync_reg <= '0;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign run = rst_sync_reg[1];

  // Period FSM: PH1 (M2 low) then PH2 (M2 high), a single counter spans both.
  typedef enum logic {PH1 = 1'b0, PH2 = 1'b1} phase_t;

  phase_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          period_start, period_last;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES || !run) begin
      state_reg <= PH1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    cnt_next   = (cnt_reg == CW'(PER - 1)) ? '0 : cnt_reg + 1'b1;
    state_next = state_reg;
    case (state_reg)
      PH1: if (cnt_reg == CW'(M2_LO - 1)) state_next = PH2;
      PH2: if (cnt_reg == CW'(PER - 1))   state_next = PH1;
      default: state_next = PH1;
    endcase
  end

  assign period_start = run && (state_reg == PH1) && (cnt_reg == '0);
  assign period_last  = run && (state_reg == PH2) && (cnt_reg == CW'(PER - 1));

  // Bus cycle datapath. The request is latched at the end of count 0, so the
  // previous cycle's address/R/W/data still hold on the pads during count 0.
  logic          pend_reg, rw_l_reg, ack_reg;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] wdata_l_reg, rdata_reg;
`ifdef APU_PADS_OPENBUS_EN
  logic [DW-1:0] ob_reg;
`endif

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES || !run) begin
      pend_reg    <= 1'b0;
      rw_l_reg    <= 1'b1;
      ack_reg     <= 1'b0;
      a_reg       <= '0;
      wdata_l_reg <= '0;
      rdata_reg   <= '0;
`ifdef APU_PADS_OPENBUS_EN
      ob_reg      <= '0;
`endif
    end else begin
      if (period_start) begin
        pend_reg <= req;
        rw_l_reg <= rw;
        // Dummy periods keep the address pads and write data where they were.
        if (req) begin
          a_reg       <= addr;
          wdata_l_reg <= wdata;
        end
      end
      // Registered so the pulse lands on count 0 of the next period.
      ack_reg <= period_last & pend_reg;
`ifdef APU_PADS_OPENBUS_EN
      if (period_last && pend_reg) begin
        if (!rw_l_reg) begin
          ob_reg <= wdata_l_reg;
        end else if (D_driven) begin
          rdata_reg <= D_in;
          ob_reg    <= D_in;
        end else begin
          rdata_reg <= ob_reg;
        end
      end
`else
      if (period_last && pend_reg && rw_l_reg) rdata_reg <= D_in;
`endif
    end
  end

  // Pad outputs decoded from registered state; run gating drops every
  // enable the moment n_RES asserts.
  always_comb begin
    M2_out = run && (state_reg == PH2);
    M2_oe  = run | ~DBG;
    A_oe   = run;
    RW_oe  = run;
    A_out  = a_reg;
    RW_out = ~(run & pend_reg & ~rw_l_reg);
    // Write data is driven through PH2 plus one hold cycle after M2 falls.
    D_oe   = run & pend_reg & ~rw_l_reg & ((state_reg == PH2) | (cnt_reg == '0));
    D_out  = wdata_l_reg;
    ack    = ack_reg;
    rdata  = rdata_reg;
  end

  // IRQ pads: sync, then require IRQ_FILT consecutive low cycles.
  logic [NIRQ-1:0] irq_acc;
  logic            n_irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NIRQ; gi++) begin : g_irq
      logic          s0_reg, s1_reg;
      logic [FW-1:0] lo_cnt_reg;

      // Sync flops reset to the idle (high) level so nothing counts at release.
      always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES || !run) begin
          s0_reg     <= 1'b1;
          s1_reg     <= 1'b1;
          lo_cnt_reg <= '0;
        end else begin
          s0_reg <= n_IRQ_pad[gi];
          s1_reg <= s0_reg;
          if (s1_reg)                            lo_cnt_reg <= '0;
          else if (lo_cnt_reg != FW'(IRQ_FILT))  lo_cnt_reg <= lo_cnt_reg + 1'b1;
        end
      end

      // Gated with the synced level so acceptance drops in the first high cycle.
      assign irq_acc[gi] = (lo_cnt_reg == FW'(IRQ_FILT)) && !s1_reg;
    end
  endgenerate

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES || !run) n_irq_reg <= 1'b1;
    else                n_irq_reg <= ~((|irq_acc) | Timer_Int);
  end

  assign n_IRQ_core = n_irq_reg;

endmodule

// File: tb/tb_apu_pads_bus_seq.sv
// Testbench for apu_pads_bus_seq (default parameters). Bus periods are
// checked cycle-by-cycle against a period-level model; IRQ and reset
// corner cases are hand sequences.
module tb_apu_pads_bus_seq;

  logic        CLK, n_RES, DBG, req, rw, ack, A_oe, RW_out, RW_oe;
  logic        D_oe, M2_out, M2_oe, Timer_Int, n_IRQ_core, d_drv;
  logic [15:0] addr, A_out;
  logic [7:0]  wdata, rdata, D_in, D_out;
  logic [0:0]  n_IRQ_pad;

  apu_pads_bus_seq dut (
    .CLK(CLK), .n_RES(n_RES), .DBG(DBG), .req(req), .rw(rw), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .A_out(A_out), .A_oe(A_oe),
    .RW_out(RW_out), .RW_oe(RW_oe), .D_in(D_in),
`ifdef APU_PADS_OPENBUS_EN
    .D_driven(d_drv),
`endif
    .D_out(D_out), .D_oe(D_oe), .M2_out(M2_out), .M2_oe(M2_oe),
    .n_IRQ_pad(n_IRQ_pad), .Timer_Int(Timer_Int), .n_IRQ_core(n_IRQ_core)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Period-level model of the bus
  logic        m_prev_req = 1'b0, m_prev_rd = 1'b1;
  logic [7:0]  m_prev_wd = 8'h00, m_rdata = 8'h00, m_ob = 8'h00;
  logic [15:0] m_a = 16'h0000;

  typedef struct {
    logic        r;
    logic        rd;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic        exp_ack;
    logic [7:0]  exp_rdata;
    int          exp_doe;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one bus period starting in its count-0 cycle; returns at the next count 0.
  task automatic run_period(input logic r, input logic rd, input logic [15:0] a,
                            input logic [7:0] wd, input logic [7:0] din,
                            input logic drv, output int doe_n);
    logic prev_wr;
    req = r; rw = rd; addr = a; wdata = wd; d_drv = drv; D_in = 8'($urandom);
    prev_wr = m_prev_req && !m_prev_rd;
    chk("ack_k0", 32'(ack), 32'(m_prev_req));
    if (m_prev_req && m_prev_rd) chk("rdata_k0", 32'(rdata), 32'(m_rdata));
    chk("m2_k0", 32'(M2_out), 32'(0));
    chk("d_oe_hold", 32'(D_oe), 32'(prev_wr));
    if (prev_wr) chk("d_out_hold", 32'(D_out), 32'(m_prev_wd));
    chk("a_out_k0", 32'(A_out), 32'(m_a));
    chk("rw_out_k0", 32'(RW_out), 32'(!prev_wr));
    if (r) m_a = a;
    doe_n = 0;
    for (int k = 1; k < 12; k++) begin
      tick();
      // Mid-period input changes must be ignored.
      req = 1'($urandom); rw = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      D_in = (k == 11) ? din : 8'($urandom);
      chk("m2", 32'(M2_out), 32'(k >= 5));
      chk("a_out", 32'(A_out), 32'(m_a));
      chk("rw_out", 32'(RW_out), 32'(r ? rd : 1'b1));
      chk("d_oe", 32'(D_oe), 32'(r && !rd && k >= 5));
      if (r && !rd && k >= 5) chk("d_out", 32'(D_out), 32'(wd));
      chk("ack_mid", 32'(ack), 32'(0));
      if (D_oe && D_out == wd) doe_n++;
    end
    tick();
    m_prev_req = r; m_prev_rd = rd; m_prev_wd = wd;
    if (r && !rd) m_ob = wd;
    if (r && rd) begin
`ifdef APU_PADS_OPENBUS_EN
      if (drv) begin m_rdata = din; m_ob = din; end
      else m_rdata = m_ob;
`else
      m_rdata = din;
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int doe, hold;
    tbl[0] = '{1'b1, 1'b1, 16'h4015, 8'h00, 8'hA5, 1'b1, 8'hA5, 0};
    tbl[1] = '{1'b1, 1'b0, 16'h2006, 8'h3C, 8'hFF, 1'b1, 8'h00, 8};
    tbl[2] = '{1'b1, 1'b1, 16'h4016, 8'h00, 8'h41, 1'b1, 8'h41, 0};
    tbl[3] = '{1'b0, 1'b0, 16'h1234, 8'h99, 8'h77, 1'b0, 8'h00, 0};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 8'h00, 1'b1, 8'h00, 8};
    tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h5A, 1'b1, 8'h00, 8};
    tbl[6] = '{1'b1, 1'b1, 16'h8000, 8'h00, 8'h00, 1'b1, 8'h00, 0};
    tbl[7] = '{1'b0, 1'b1, 16'hABCD, 8'h00, 8'h12, 1'b0, 8'h00, 0};

    n_RES = 1'b0; DBG = 1'b0; req = 1'b0; rw = 1'b1; addr = '0; wdata = '0;
    D_in = '0; d_drv = 1'b1; n_IRQ_pad = 1'b1; Timer_Int = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_m2_oe", 32'(M2_oe), 32'(1));
    chk("rst_m2_out", 32'(M2_out), 32'(0));
    chk("rst_oes", 32'({A_oe, RW_oe, D_oe}), 32'(0));
    chk("rst_pads", 32'({A_out, RW_out, D_out}), {16'h0000, 1'b1, 8'h00});
    chk("rst_ack", 32'({ack, rdata}), 32'(0));
    chk("rst_irq", 32'(n_IRQ_core), 32'(1));
    DBG = 1'b1; #1;
    chk("rst_dbg_m2_oe", 32'(M2_oe), 32'(0));
    DBG = 1'b0; #1;
    chk("rst_m2_oe_back", 32'(M2_oe), 32'(1));

    // Release: internal reset lifts on the second edge
    n_RES = 1'b1;
    tick();
    chk("rel_edge1_a_oe", 32'(A_oe), 32'(0));
    tick();
    chk("rel_edge2_oes", 32'({A_oe, RW_oe, M2_oe, D_oe}), 32'(4'b1110));
    chk("rel_edge2_m2", 32'(M2_out), 32'(0));

    // Table-driven periods
    for (int i = 0; i < 8; i++) begin
      run_period(tbl[i].r, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].din, 1'b1, doe);
      hold = (D_oe && D_out == tbl[i].wd) ? 1 : 0;
      chk("tbl_ack", 32'(ack), 32'(tbl[i].exp_ack));
      if (tbl[i].exp_ack && tbl[i].rd) chk("tbl_rdata", 32'(rdata), 32'(tbl[i].exp_rdata));
      chk("tbl_doe_cycles", 32'(doe + hold), 32'(tbl[i].exp_doe));
    end

    // Random periods
    for (int i = 0; i < 40; i++) begin
      logic rr, rd, dv;
      rr = ($urandom % 4) != 0;
      rd = 1'($urandom);
`ifdef APU_PADS_OPENBUS_EN
      dv = 1'($urandom);
`else
      dv = 1'b1;
`endif
      run_period(rr, rd, 16'($urandom), 8'($urandom), 8'($urandom), dv, doe);
    end

    // Reset during PH2 of a write
    req = 1'b1; rw = 1'b0; addr = 16'h2006; wdata = 8'h3C; d_drv = 1'b1;
    repeat (7) tick();
    chk("midrst_pre_d_oe", 32'(D_oe), 32'(1));
    n_RES = 1'b0; #1;
    chk("midrst_oes", 32'({A_oe, RW_oe, D_oe}), 32'(0));
    chk("midrst_m2", 32'(M2_out), 32'(0));
    chk("midrst_pads", 32'({A_out, RW_out}), {15'h0, 16'h0000, 1'b1});
    req = 1'b0;
    repeat (3) tick();
    chk("midrst_ack", 32'(ack), 32'(0));
    n_RES = 1'b1;
    tick();
    chk("midrst_rel1_a_oe", 32'(A_oe), 32'(0));
    tick();
    chk("midrst_rel2_ack", 32'(ack), 32'(0));
    chk("midrst_rel2_a_oe", 32'(A_oe), 32'(1));
    m_prev_req = 1'b0; m_prev_rd = 1'b1; m_a = 16'h0000; m_rdata = 8'h00; m_ob = 8'h00;
    run_period(1'b1, 1'b1, 16'h55AA, 8'h00, 8'hC3, 1'b1, doe);
    run_period(1'b0, 1'b1, 16'h0000, 8'h00, 8'h00, 1'b1, doe);

`ifdef APU_PADS_OPENBUS_EN
    run_period(1'b1, 1'b0, 16'h2007, 8'h5A, 8'h00, 1'b1, doe);
    run_period(1'b1, 1'b1, 16'h4000, 8'h00, 8'hEE, 1'b0, doe);
    chk("ob_undriven", 32'(rdata), 32'(8'h5A));
    run_period(1'b1, 1'b1, 16'h4001, 8'h00, 8'h11, 1'b1, doe);
    chk("ob_driven", 32'(rdata), 32'(8'h11));
    run_period(1'b0, 1'b1, 16'h0000, 8'h00, 8'h00, 1'b1, doe);
`endif

    // IRQ filter
    req = 1'b0; n_IRQ_pad = 1'b1; Timer_Int = 1'b0;
    repeat (4) tick();
    chk("irq_idle", 32'(n_IRQ_core), 32'(1));
    n_IRQ_pad = 1'b0;
    tick();
    n_IRQ_pad = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("irq_glitch", 32'(n_IRQ_core), 32'(1));
    end
    n_IRQ_pad = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("irq_assert", 32'(n_IRQ_core), 32'(e < 5));
    end
    n_IRQ_pad = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("irq_deassert", 32'(n_IRQ_core), 32'(e >= 3));
    end
    Timer_Int = 1'b1;
    tick();
    chk("timer_assert", 32'(n_IRQ_core), 32'(0));
    Timer_Int = 1'b0;
    tick();
    chk("timer_deassert", 32'(n_IRQ_core), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
